// File: rtl/tournament_predictor_pkg.sv
// Shared types and defaults for the tournament branch predictor.
// Provides the 2-bit saturating counter type, its reset/limit constants,
// the default table widths and the counter update helper.
package tournament_predictor_pkg;

  typedef logic [1:0] sat2_t;

  localparam sat2_t SAT2_MIN     = 2'b00;
  localparam sat2_t SAT2_WEAK_NT = 2'b01;
  localparam sat2_t SAT2_MAX     = 2'b11;

  localparam int DEFAULT_GHR_W      = 8;
  localparam int DEFAULT_BHT_IDX_W  = 6;
  localparam int DEFAULT_LHR_W      = 8;
  localparam int DEFAULT_TOUR_IDX_W = 8;

  // Saturating +1/-1; simultaneous inc and dec cancel out.
  function automatic sat2_t sat2_next(sat2_t cur, logic inc, logic dec);
    sat2_t nxt;
    nxt = cur;
    if (inc && !dec && (cur != SAT2_MAX)) begin
      nxt = cur + 2'd1;
    end else if (dec && !inc && (cur != SAT2_MIN)) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tournament_predictor_sat_counter_table.sv
// Table of 2-bit saturating counters with one combinational read port and
// one inc/dec write port. Used for the local PHT, global PHT and chooser.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (entries -> 2'b01)
//   rd_idx/rd_val   combinational lookup
//   wr_idx,inc,dec  saturating update of entry wr_idx on the clock edge
module sat_counter_table
  import tournament_predictor_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output sat2_t            rd_val,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             inc,
  input  logic             dec
);

  sat2_t tbl_q [2**IDX_W];
  sat2_t tbl_d [2**IDX_W];

  // Reads see the registered contents, so a same-cycle write is not visible.
  assign rd_val = tbl_q[rd_idx];

  always_comb begin
    tbl_d = tbl_q;
    tbl_d[wr_idx] = sat2_next(tbl_q[wr_idx], inc, dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        tbl_q[i] <= SAT2_WEAK_NT;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch-direction predictor: local (BHT -> local PHT) and gshare
// global predictors, selected per PC by a chooser table. Sits upstream of the
// stall unit, which compares the registered ID-stage predictions with the
// resolved direction and issues the training strobes.
// Optional feature macro: TOURNAMENT_PREDICTOR_BYPASS_EN forwards same-cycle
// GHR/BHT updates into the IF lookup indices.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_pc / if_br_pr          IF lookup and combinational prediction
//   if_id_reg_load/flush      capture / clear the ID snapshot (flush wins)
//   id_br_en                  resolved direction of the branch in ID
//   ghr_load, bht_load        history shift strobes
//   increment/decrement_pht   local+global PHT training at the ID indices
//   increment/decrement_tournament_pht  chooser training at the ID index
//   id_local_pr/id_global_pr/id_br_pr   registered ID-stage predictions
module tournament_predictor
  import tournament_predictor_pkg::*;
#(
  parameter int GHR_W      = DEFAULT_GHR_W,
  parameter int BHT_IDX_W  = DEFAULT_BHT_IDX_W,
  parameter int LHR_W      = DEFAULT_LHR_W,
  parameter int TOUR_IDX_W = DEFAULT_TOUR_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_br_pr,
  input  logic        if_id_reg_load,
  input  logic        if_id_reg_flush,
  input  logic        id_br_en,
  input  logic        ghr_load,
  input  logic        bht_load,
  input  logic        increment_pht,
  input  logic        decrement_pht,
  input  logic        increment_tournament_pht,
  input  logic        decrement_tournament_pht,
  output logic        id_local_pr,
  output logic        id_global_pr,
  output logic        id_br_pr
);

  logic [GHR_W-1:0]      ghr_q, ghr_d, ghr_view;
  logic [LHR_W-1:0]      bht_q [2**BHT_IDX_W];
  logic [LHR_W-1:0]      bht_d [2**BHT_IDX_W];
  logic [LHR_W-1:0]      bht_shift;

  logic [BHT_IDX_W-1:0]  if_bidx;
  logic [LHR_W-1:0]      if_lidx;
  logic [GHR_W-1:0]      if_gidx;
  logic [TOUR_IDX_W-1:0] if_tidx;
  sat2_t                 lpht_rd, gpht_rd, chooser_rd;
  logic                  if_local_pr, if_global_pr;

  // ID snapshot of the lookup; all training is addressed through it.
  logic [BHT_IDX_W-1:0]  bidx_q, bidx_d;
  logic [LHR_W-1:0]      lidx_q, lidx_d;
  logic [GHR_W-1:0]      gidx_q, gidx_d;
  logic [TOUR_IDX_W-1:0] tidx_q, tidx_d;
  logic                  local_pr_q, local_pr_d;
  logic                  global_pr_q, global_pr_d;
  logic                  br_pr_q, br_pr_d;

  // Only a slice of the PC indexes the tables; reduce it so every bit has a load.
  logic unused_pc;
  assign unused_pc = ^if_pc;

  // Next history state; the shifted BHT entry is the one recorded in ID.
  always_comb begin
    ghr_d = ghr_q;
    if (ghr_load) begin
      ghr_d = {ghr_q[GHR_W-2:0], id_br_en};
    end
    bht_shift = {bht_q[bidx_q][LHR_W-2:0], id_br_en};
    bht_d = bht_q;
    if (bht_load) begin
      bht_d[bidx_q] = bht_shift;
    end
  end

  assign if_bidx = if_pc[BHT_IDX_W+1:2];
  assign if_tidx = if_pc[TOUR_IDX_W+1:2];

  // IF index formation, optionally forwarding this cycle's history updates.
  always_comb begin
`ifdef TOURNAMENT_PREDICTOR_BYPASS_EN
    ghr_view = ghr_d;
    if (bht_load && (if_bidx == bidx_q)) begin
      if_lidx = bht_shift;
    end else begin
      if_lidx = bht_q[if_bidx];
    end
`else
    ghr_view = ghr_q;
    if_lidx  = bht_q[if_bidx];
`endif
    if_gidx = ghr_view ^ if_pc[GHR_W+1:2];
  end

  sat_counter_table #(.IDX_W(LHR_W)) u_lpht (
    .clk(clk), .rst(rst),
    .rd_idx(if_lidx), .rd_val(lpht_rd),
    .wr_idx(lidx_q), .inc(increment_pht), .dec(decrement_pht)
  );

  sat_counter_table #(.IDX_W(GHR_W)) u_gpht (
    .clk(clk), .rst(rst),
    .rd_idx(if_gidx), .rd_val(gpht_rd),
    .wr_idx(gidx_q), .inc(increment_pht), .dec(decrement_pht)
  );

  sat_counter_table #(.IDX_W(TOUR_IDX_W)) u_chooser (
    .clk(clk), .rst(rst),
    .rd_idx(if_tidx), .rd_val(chooser_rd),
    .wr_idx(tidx_q), .inc(increment_tournament_pht),
    .dec(decrement_tournament_pht)
  );

  assign if_local_pr  = lpht_rd[1];
  assign if_global_pr = gpht_rd[1];
  assign if_br_pr     = chooser_rd[1] ? if_global_pr : if_local_pr;

  // Flush has priority over load so a squashed slot never trains anything.
  always_comb begin
    bidx_d      = bidx_q;
    lidx_d      = lidx_q;
    gidx_d      = gidx_q;
    tidx_d      = tidx_q;
    local_pr_d  = local_pr_q;
    global_pr_d = global_pr_q;
    br_pr_d     = br_pr_q;
    if (if_id_reg_flush) begin
      bidx_d      = '0;
      lidx_d      = '0;
      gidx_d      = '0;
      tidx_d      = '0;
      local_pr_d  = 1'b0;
      global_pr_d = 1'b0;
      br_pr_d     = 1'b0;
    end else if (if_id_reg_load) begin
      bidx_d      = if_bidx;
      lidx_d      = if_lidx;
      gidx_d      = if_gidx;
      tidx_d      = if_tidx;
      local_pr_d  = if_local_pr;
      global_pr_d = if_global_pr;
      br_pr_d     = if_br_pr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q       <= '0;
      for (int i = 0; i < 2**BHT_IDX_W; i++) begin
        bht_q[i] <= '0;
      end
      bidx_q      <= '0;
      lidx_q      <= '0;
      gidx_q      <= '0;
      tidx_q      <= '0;
      local_pr_q  <= 1'b0;
      global_pr_q <= 1'b0;
      br_pr_q     <= 1'b0;
    end else begin
      ghr_q       <= ghr_d;
      bht_q       <= bht_d;
      bidx_q      <= bidx_d;
      lidx_q      <= lidx_d;
      gidx_q      <= gidx_d;
      tidx_q      <= tidx_d;
      local_pr_q  <= local_pr_d;
      global_pr_q <= global_pr_d;
      br_pr_q     <= br_pr_d;
    end
  end

  assign id_local_pr  = local_pr_q;
  assign id_global_pr = global_pr_q;
  assign id_br_pr     = br_pr_q;

endmodule

// File: tb/tb_tournament_predictor.sv
// Self-checking bench for tournament_predictor. A behavioural reference model
// of the predictor tables predicts if_br_pr each cycle and pushes the expected
// ID-stage outputs into a queue, which is popped after each clock edge.
module tb_tournament_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_br_pr;
  logic        if_id_reg_load = 1'b0;
  logic        if_id_reg_flush = 1'b0;
  logic        id_br_en = 1'b0;
  logic        ghr_load = 1'b0;
  logic        bht_load = 1'b0;
  logic        increment_pht = 1'b0;
  logic        decrement_pht = 1'b0;
  logic        increment_tournament_pht = 1'b0;
  logic        decrement_tournament_pht = 1'b0;
  logic        id_local_pr, id_global_pr, id_br_pr;

  int checks = 0;
  int failures = 0;

  tournament_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_br_pr(if_br_pr),
    .if_id_reg_load(if_id_reg_load), .if_id_reg_flush(if_id_reg_flush),
    .id_br_en(id_br_en), .ghr_load(ghr_load), .bht_load(bht_load),
    .increment_pht(increment_pht), .decrement_pht(decrement_pht),
    .increment_tournament_pht(increment_tournament_pht),
    .decrement_tournament_pht(decrement_tournament_pht),
    .id_local_pr(id_local_pr), .id_global_pr(id_global_pr), .id_br_pr(id_br_pr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_ghr;
  logic [7:0] m_bht [64];
  logic [1:0] m_lpht [256];
  logic [1:0] m_gpht [256];
  logic [1:0] m_ch [256];
  logic [5:0] s_bidx;
  logic [7:0] s_lidx, s_gidx, s_tidx;
  logic       s_lpr, s_gpr, s_pr;
  // Current-cycle lookup predicted by the model
  logic [5:0] e_bidx;
  logic [7:0] e_lidx, e_gidx, e_tidx;
  logic       e_lpr, e_gpr, e_pr;
  logic [2:0] exp_q [$];
  logic [2:0] exp_id;

  function automatic logic [1:0] model_sat(logic [1:0] c, logic inc, logic dec);
    if (inc && !dec) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    if (dec && !inc) return (c == 2'd0) ? 2'd0 : c - 2'd1;
    return c;
  endfunction

  task automatic model_reset();
    m_ghr = '0;
    for (int i = 0; i < 64; i++) m_bht[i] = '0;
    for (int i = 0; i < 256; i++) begin
      m_lpht[i] = 2'b01;
      m_gpht[i] = 2'b01;
      m_ch[i]   = 2'b01;
    end
    s_bidx = '0; s_lidx = '0; s_gidx = '0; s_tidx = '0;
    s_lpr = 1'b0; s_gpr = 1'b0; s_pr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_lookup();
    logic [7:0] gv, lh;
    e_bidx = if_pc[7:2];
    e_tidx = if_pc[9:2];
    gv = m_ghr;
    lh = m_bht[e_bidx];
`ifdef TOURNAMENT_PREDICTOR_BYPASS_EN
    if (ghr_load) gv = {m_ghr[6:0], id_br_en};
    if (bht_load && (e_bidx == s_bidx)) lh = {m_bht[s_bidx][6:0], id_br_en};
`endif
    e_gidx = gv ^ if_pc[9:2];
    e_lidx = lh;
    e_lpr = m_lpht[e_lidx][1];
    e_gpr = m_gpht[e_gidx][1];
    e_pr  = m_ch[e_tidx][1] ? e_gpr : e_lpr;
  endtask

  task automatic set_inputs(input logic [31:0] pc, input logic load, input logic flush,
                            input logic br, input logic gl, input logic bl,
                            input logic inc, input logic dec, input logic ti, input logic td);
    @(negedge clk);
    if_pc = pc; if_id_reg_load = load; if_id_reg_flush = flush; id_br_en = br;
    ghr_load = gl; bht_load = bl; increment_pht = inc; decrement_pht = dec;
    increment_tournament_pht = ti; decrement_tournament_pht = td;
    #1;
    model_lookup();
  endtask

  task automatic clock_edge();
    if (if_id_reg_flush) exp_q.push_back(3'b000);
    else if (if_id_reg_load) exp_q.push_back({e_lpr, e_gpr, e_pr});
    else exp_q.push_back({s_lpr, s_gpr, s_pr});
    m_lpht[s_lidx] = model_sat(m_lpht[s_lidx], increment_pht, decrement_pht);
    m_gpht[s_gidx] = model_sat(m_gpht[s_gidx], increment_pht, decrement_pht);
    m_ch[s_tidx]   = model_sat(m_ch[s_tidx], increment_tournament_pht, decrement_tournament_pht);
    if (bht_load) m_bht[s_bidx] = {m_bht[s_bidx][6:0], id_br_en};
    if (ghr_load) m_ghr = {m_ghr[6:0], id_br_en};
    if (if_id_reg_flush) begin
      s_bidx = '0; s_lidx = '0; s_gidx = '0; s_tidx = '0;
      s_lpr = 1'b0; s_gpr = 1'b0; s_pr = 1'b0;
    end else if (if_id_reg_load) begin
      s_bidx = e_bidx; s_lidx = e_lidx; s_gidx = e_gidx; s_tidx = e_tidx;
      s_lpr = e_lpr; s_gpr = e_gpr; s_pr = e_pr;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) exp_id = 3'bxxx;
    else exp_id = exp_q.pop_front();
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_id_reg_load = 0; if_id_reg_flush = 0; id_br_en = 0; ghr_load = 0; bht_load = 0;
    increment_pht = 0; decrement_pht = 0;
    increment_tournament_pht = 0; decrement_tournament_pht = 0;
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h40; pcs[2] = 32'h3fc; pcs[3] = 32'hdead_beec;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if_pc = pcs[i];
      #1;
      checks++;
      if (if_br_pr !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_if_br_pr pc=%h got=%b want=0", pcs[i], if_br_pr);
      end
    end
    checks++;
    if ({id_local_pr, id_global_pr, id_br_pr} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_id got=%b want=000", {id_local_pr, id_global_pr, id_br_pr});
    end
    checks++;
    if (dut.ghr_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_ghr got=%h want=00", dut.ghr_q);
    end
  endtask

  task automatic test_train_local();
    set_inputs(32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_inputs(32'h40, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      else       set_inputs(32'h40, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      checks++;
      if (if_br_pr !== e_pr) begin
        failures++;
        $display("[TB] FAIL train_if_pr step=%0d got=%b want=%b", i, if_br_pr, e_pr);
      end
      clock_edge();
      checks++;
      if ({id_local_pr, id_global_pr, id_br_pr} !== exp_id) begin
        failures++;
        $display("[TB] FAIL train_id step=%0d got=%b want=%b", i,
                 {id_local_pr, id_global_pr, id_br_pr}, exp_id);
      end
    end
    checks++;
    if ({dut.u_lpht.tbl_q[0], dut.u_gpht.tbl_q[8'h10], dut.u_chooser.tbl_q[8'h10]} !== 6'b11_11_01) begin
      failures++;
      $display("[TB] FAIL train_sat got=%b%b%b want=111101", dut.u_lpht.tbl_q[0],
               dut.u_gpht.tbl_q[8'h10], dut.u_chooser.tbl_q[8'h10]);
    end
    checks++;
    if ({dut.ghr_q, dut.bht_q[6'h10]} !== 16'h0707) begin
      failures++;
      $display("[TB] FAIL train_hist got=%h/%h want=07/07", dut.ghr_q, dut.bht_q[6'h10]);
    end
    // Capture 0x40 with local history 0x07, then train that local entry once.
    set_inputs(32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    set_inputs(32'h40, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    clock_edge();
    set_inputs(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut.u_lpht.tbl_q[7] !== 2'b10) begin
      failures++;
      $display("[TB] FAIL lpht7 got=%b want=10", dut.u_lpht.tbl_q[7]);
    end
    checks++;
    if (if_br_pr !== 1'b1 || e_pr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL local_follow got=%b want=1", if_br_pr);
    end
    clock_edge();
  endtask

  task automatic test_chooser();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_inputs(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else       set_inputs(32'h40, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      clock_edge();
    end
    set_inputs(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut.u_chooser.tbl_q[8'h10] !== 2'b10) begin
      failures++;
      $display("[TB] FAIL chooser_val got=%b want=10", dut.u_chooser.tbl_q[8'h10]);
    end
    checks++;
    if (if_br_pr !== e_gpr || e_pr !== e_gpr) begin
      failures++;
      $display("[TB] FAIL chooser_global got=%b want=%b", if_br_pr, e_gpr);
    end
    clock_edge();
  endtask

  task automatic test_flush();
    set_inputs(32'h140, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    checks++;
    if ({id_local_pr, id_global_pr, id_br_pr} !== 3'b000 || exp_id !== 3'b000) begin
      failures++;
      $display("[TB] FAIL flush_wins got=%b want=000", {id_local_pr, id_global_pr, id_br_pr});
    end
    set_inputs(32'h140, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_br_pr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_if_pr got=%b want=1", if_br_pr);
    end
    clock_edge();
    checks++;
    if (id_br_pr !== 1'b1 || {id_local_pr, id_global_pr, id_br_pr} !== exp_id) begin
      failures++;
      $display("[TB] FAIL load_id got=%b want=%b", {id_local_pr, id_global_pr, id_br_pr}, exp_id);
    end
  endtask

  task automatic test_inc_dec_both();
    logic [1:0] l_before, g_before;
    l_before = m_lpht[s_lidx];
    g_before = m_gpht[s_gidx];
    set_inputs(32'h140, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    clock_edge();
    checks++;
    if (dut.u_lpht.tbl_q[s_lidx] !== l_before || dut.u_gpht.tbl_q[s_gidx] !== g_before) begin
      failures++;
      $display("[TB] FAIL inc_dec_both got=%b/%b want=%b/%b", dut.u_lpht.tbl_q[s_lidx],
               dut.u_gpht.tbl_q[s_gidx], l_before, g_before);
    end
  endtask

  task automatic test_collision();
    logic want;
    do_reset();
    set_inputs(32'h04, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      set_inputs(32'h04, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      clock_edge();
    end
    set_inputs(32'h04, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`ifdef TOURNAMENT_PREDICTOR_BYPASS_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    checks++;
    if (if_br_pr !== want || e_pr !== want) begin
      failures++;
      $display("[TB] FAIL ghr_collision got=%b want=%b", if_br_pr, want);
    end
    clock_edge();
    checks++;
    if (dut.ghr_q !== 8'h01) begin
      failures++;
      $display("[TB] FAIL ghr_shift got=%h want=01", dut.ghr_q);
    end
    // Asynchronous reset between clock edges.
    set_inputs(32'h04, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    rst = 1'b1;
    #1;
    checks++;
    if (dut.ghr_q !== 8'h00 || if_br_pr !== 1'b0 ||
        {id_local_pr, id_global_pr, id_br_pr} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL async_reset ghr=%h if=%b id=%b want=00/0/000", dut.ghr_q, if_br_pr,
               {id_local_pr, id_global_pr, id_br_pr});
    end
    model_reset();
    if_id_reg_load = 0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5];
    pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h04; pcs[3] = 32'h44; pcs[4] = 32'h3c0;
    for (int i = 0; i < 80; i++) begin
      logic [9:0] r;
      r = 10'($urandom);
      set_inputs(pcs[$urandom_range(0, 4)], r[0], (r[1] & r[2]), r[3], r[4], r[5],
                 r[6], r[7] & r[6], r[8], r[9]);
      checks++;
      if (if_br_pr !== e_pr) begin
        failures++;
        $display("[TB] FAIL b2b_if_pr cyc=%0d got=%b want=%b", i, if_br_pr, e_pr);
      end
      clock_edge();
      checks++;
      if ({id_local_pr, id_global_pr, id_br_pr} !== exp_id) begin
        failures++;
        $display("[TB] FAIL b2b_id cyc=%0d got=%b want=%b", i,
                 {id_local_pr, id_global_pr, id_br_pr}, exp_id);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_train_local();
    test_chooser();
    test_flush();
    test_inc_dec_both();
    test_collision();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
